ss3_datastack: RTL and testbench

SS3_DATASTACK -- requirements
Module: ss3_datastack

---
 rtl/ss3_pkg.sv | 18 +
 rtl/ss3_stack_ram.sv | 26 ++
 rtl/ss3_datastack.sv | 158 +++++++++++++++
 tb/tb_ss3_datastack.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ss3_pkg.sv
// Shared definitions for the ss3 data stack: op encodings and default geometry.
package ss3_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 256;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_LOAD  = 3'b011,
    OP_DUP   = 3'b100,
    OP_SWAP  = 3'b101,
    OP_CLEAR = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

endpackage

// File: rtl/ss3_stack_ram.sv
// Backing store for the entries below the top-of-stack register.
// One synchronous write port, one combinational read port, no reset.
module ss3_stack_ram #(
  parameter int WIDTH = 16,
  parameter int WORDS = 255,
  parameter int AW    = 8
) (
  input  logic             CLK,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:WORDS-1];

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ss3_datastack.sv
// Hardware data stack: a top-of-stack register in front of a (DEPTH-1)-word RAM,
// with a depth counter and sticky overflow/underflow flags.
module ss3_datastack
  import ss3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_tos;
  logic [DW-1:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_tos_nx;
  logic [DW-1:0]    w_depth_nx;
  logic             w_ovf_nx;
  logic             w_unf_nx;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [AW-1:0]    w_raddr;
  logic [WIDTH-1:0] w_rdata;
  logic             w_full;
  logic             w_empty;
  logic             w_ge2;
  logic [AW-1:0]    w_dm1;
  logic [AW-1:0]    w_dm2;
  op_e              w_op;

  assign w_op    = op_e'(op);
  assign w_full  = (r_depth == DW'(DEPTH));
  assign w_empty = (r_depth == '0);
  assign w_ge2   = (r_depth >= DW'(2));

  // Modular arithmetic on the low bits is exact for every depth at which
  // these addresses are actually used (depth-1 for 1..DEPTH-1, depth-2 for 2..DEPTH).
  assign w_dm1   = r_depth[AW-1:0] - AW'(1);
  assign w_dm2   = r_depth[AW-1:0] - AW'(2);
  assign w_raddr = w_ge2 ? w_dm2 : '0;

  ss3_stack_ram #(
    .WIDTH (WIDTH),
    .WORDS (DEPTH - 1),
    .AW    (AW)
  ) u_ram (
    .CLK     (CLK),
    .i_we    (w_we && reset),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_tos_nx   = r_tos;
    w_depth_nx = r_depth;
    w_ovf_nx   = r_ovf;
    w_unf_nx   = r_unf;
    w_we       = 1'b0;
    w_waddr    = w_dm1;
    w_wdata    = r_tos;
    case (w_op)
      OP_PUSH: begin
        if (w_full) begin
          w_ovf_nx = 1'b1;
        end else if (w_empty) begin
          w_tos_nx   = din;
          w_depth_nx = DW'(1);
        end else begin
          w_we       = 1'b1;
          w_tos_nx   = din;
          w_depth_nx = r_depth + DW'(1);
        end
      end
      OP_POP: begin
        if (w_empty) begin
          w_unf_nx = 1'b1;
        end else if (w_ge2) begin
          w_tos_nx   = w_rdata;
          w_depth_nx = r_depth - DW'(1);
        end else begin
          w_tos_nx   = '0;
          w_depth_nx = '0;
        end
      end
      OP_LOAD: begin
        w_tos_nx = din;
        if (w_empty) w_depth_nx = DW'(1);
      end
      OP_DUP: begin
        if (w_empty) begin
          w_unf_nx = 1'b1;
        end else if (w_full) begin
          w_ovf_nx = 1'b1;
        end else begin
          w_we       = 1'b1;
          w_depth_nx = r_depth + DW'(1);
        end
      end
      OP_SWAP: begin
        // Read of the old entry and write of the old tos share one cycle.
        if (w_ge2) begin
          w_we     = 1'b1;
          w_waddr  = w_dm2;
          w_tos_nx = w_rdata;
        end else begin
          w_unf_nx = 1'b1;
        end
      end
      OP_CLEAR: begin
        w_tos_nx   = '0;
        w_depth_nx = '0;
        w_ovf_nx   = 1'b0;
        w_unf_nx   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_tos   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_tos   <= w_tos_nx;
      r_depth <= w_depth_nx;
      r_ovf   <= w_ovf_nx;
      r_unf   <= w_unf_nx;
    end
  end

  assign tos       = r_tos;
  assign nos       = w_ge2 ? w_rdata : '0;
  assign depth     = r_depth;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_ss3_datastack.sv
// Directed, table-driven bench for ss3_datastack at WIDTH=16, DEPTH=4.
module tb_ss3_datastack;

  localparam int W = 16;
  localparam int D = 4;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, LOAD = 3'b011;
  localparam logic [2:0] DUP = 3'b100, SWAP = 3'b101, CLR = 3'b110, RSV = 3'b111;

  logic         CLK;
  logic         reset;
  logic [2:0]   op;
  logic [W-1:0] din;
  logic [W-1:0] tos;
  logic [W-1:0] nos;
  logic [2:0]   depth;
  logic         full;
  logic         empty;
  logic         overflow;
  logic         underflow;

  int checks   = 0;
  int failures = 0;

  ss3_datastack #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .op        (op),
    .din       (din),
    .tos       (tos),
    .nos       (nos),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         rst_n;
    logic [2:0]   op;
    logic [W-1:0] din;
    logic [W-1:0] e_tos;
    logic [W-1:0] e_nos;
    logic [2:0]   e_depth;
    logic         e_full;
    logic         e_empty;
    logic         e_ovf;
    logic         e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] o, input logic [W-1:0] d,
                     input logic [W-1:0] t, input logic [W-1:0] n, input logic [2:0] dp,
                     input logic f, input logic e, input logic ov, input logic un);
    vec_t v;
    v.rst_n = r; v.op = o; v.din = d; v.e_tos = t; v.e_nos = n; v.e_depth = dp;
    v.e_full = f; v.e_empty = e; v.e_ovf = ov; v.e_unf = un;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver: apply one op across one rising edge, return 1 time unit after it
  task automatic step(input logic r, input logic [2:0] o, input logic [W-1:0] d);
    reset = r; op = o; din = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".tos"},   32'(tos),       32'(v.e_tos));
    chk({tag, ".nos"},   32'(nos),       32'(v.e_nos));
    chk({tag, ".depth"}, 32'(depth),     32'(v.e_depth));
    chk({tag, ".full"},  32'(full),      32'(v.e_full));
    chk({tag, ".empty"}, 32'(empty),     32'(v.e_empty));
    chk({tag, ".ovf"},   32'(overflow),  32'(v.e_ovf));
    chk({tag, ".unf"},   32'(underflow), 32'(v.e_unf));
  endtask

  initial begin
    reset = 1'b0; op = NOP; din = '0;

    //   rst op    din      tos      nos      dp f e ov un
    add(0, NOP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0); // reset state
    add(1, PUSH, 16'h0011, 16'h0011, 16'h0000, 1, 0, 0, 0, 0);
    add(1, PUSH, 16'h0022, 16'h0022, 16'h0011, 2, 0, 0, 0, 0);
    add(1, PUSH, 16'h0033, 16'h0033, 16'h0022, 3, 0, 0, 0, 0);
    add(1, PUSH, 16'h0044, 16'h0044, 16'h0033, 4, 1, 0, 0, 0);
    add(1, PUSH, 16'h0055, 16'h0044, 16'h0033, 4, 1, 0, 1, 0); // overflow
    add(1, POP,  16'h0000, 16'h0033, 16'h0022, 3, 0, 0, 1, 0);
    add(1, POP,  16'h0000, 16'h0022, 16'h0011, 2, 0, 0, 1, 0);
    add(1, POP,  16'h0000, 16'h0011, 16'h0000, 1, 0, 0, 1, 0);
    add(1, POP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 0);
    add(1, POP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 1); // underflow
    add(1, CLR,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
    add(1, PUSH, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0, 0, 0);
    add(1, PUSH, 16'hBBBB, 16'hBBBB, 16'hAAAA, 2, 0, 0, 0, 0);
    add(1, SWAP, 16'h0000, 16'hAAAA, 16'hBBBB, 2, 0, 0, 0, 0);
    add(1, DUP,  16'h0000, 16'hAAAA, 16'hAAAA, 3, 0, 0, 0, 0);
    add(0, PUSH, 16'h5555, 16'h0000, 16'h0000, 0, 0, 1, 0, 0); // reset beats push
    add(1, SWAP, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 1);
    add(1, CLR,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
    add(1, LOAD, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 0, 0);
    add(1, LOAD, 16'h5678, 16'h5678, 16'h0000, 1, 0, 0, 0, 0);
    add(1, RSV,  16'hFFFF, 16'h5678, 16'h0000, 1, 0, 0, 0, 0); // reserved = nop
    add(1, DUP,  16'h0000, 16'h5678, 16'h5678, 2, 0, 0, 0, 0);
    add(1, PUSH, 16'h9999, 16'h9999, 16'h5678, 3, 0, 0, 0, 0);
    add(1, SWAP, 16'h0000, 16'h5678, 16'h9999, 3, 0, 0, 0, 0);
    add(1, DUP,  16'h0000, 16'h5678, 16'h5678, 4, 1, 0, 0, 0);
    add(1, DUP,  16'h0000, 16'h5678, 16'h5678, 4, 1, 0, 1, 0); // dup when full
    add(1, POP,  16'h0000, 16'h5678, 16'h9999, 3, 0, 0, 1, 0);
    add(1, POP,  16'h0000, 16'h9999, 16'h5678, 2, 0, 0, 1, 0);
    add(1, POP,  16'h0000, 16'h5678, 16'h0000, 1, 0, 0, 1, 0);
    add(1, SWAP, 16'h0000, 16'h5678, 16'h0000, 1, 0, 0, 1, 1); // swap at depth 1
    add(1, POP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 1);
    add(1, DUP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 1); // dup when empty
    add(1, LOAD, 16'h00C3, 16'h00C3, 16'h0000, 1, 0, 0, 1, 1); // load on empty

    step(1'b0, NOP, '0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].op, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset held for several cycles under a stream of pushes clears sticky flags.
    step(1'b0, PUSH, 16'h7777);
    step(1'b0, PUSH, 16'h8888);
    chk("hold_rst.depth", 32'(depth), 32'd0);
    chk("hold_rst.tos", 32'(tos), 32'd0);
    chk("hold_rst.ovf", 32'(overflow), 32'd0);
    chk("hold_rst.unf", 32'(underflow), 32'd0);

    // Fill, overflow, then reset mid-sequence and confirm the stack restarts cleanly.
    step(1'b1, PUSH, 16'h0101);
    step(1'b1, PUSH, 16'h0202);
    step(1'b1, PUSH, 16'h0303);
    step(1'b1, PUSH, 16'h0404);
    step(1'b1, PUSH, 16'h0505);
    chk("seq_ovf.ovf", 32'(overflow), 32'd1);
    chk("seq_ovf.tos", 32'(tos), 32'h0404);
    step(1'b0, POP, '0);
    chk("seq_rst.ovf", 32'(overflow), 32'd0);
    chk("seq_rst.empty", 32'(empty), 32'd1);
    step(1'b1, PUSH, 16'hBEEF);
    chk("seq_post.tos", 32'(tos), 32'hBEEF);
    chk("seq_post.nos", 32'(nos), 32'd0);
    step(1'b1, PUSH, 16'hCAFE);
    chk("seq_post2.nos", 32'(nos), 32'hBEEF);
    chk("seq_post2.depth", 32'(depth), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
